// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    function automatic int bpw(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes big-endian into words and keeps the running XOR of data bytes.
module word_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic              word_done_o,
    output logic [DATA_W-1:0] word_o,
    output logic [7:0]        csum_o
);

    localparam int BPW   = bpw(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              done_q;
    logic [7:0]        csum_q;

    assign last_byte_o = (cnt_q == CNT_W'(BPW - 1));
    assign word_done_o = done_q;
    assign word_o      = shift_q;
    assign csum_o      = csum_q;

    // done_q pulses the cycle after the final byte of a word lands in shift_q.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            done_q <= byte_valid_i && last_byte_o;
            if (byte_valid_i) begin
                shift_q <= (shift_q << 8) | DATA_W'(byte_i);
                csum_q  <= csum_q ^ byte_i;
                cnt_q   <= last_byte_o ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory with XOR checksum and core hold.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_LOAD  | accepting data bytes, writing one word per BPW bytes
//   ST_CHECK | waiting for the checksum byte
//   ST_DONE  | load verified, core released
//   ST_ERR   | bad length or checksum mismatch, core held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q;
    logic              in_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [DATA_W-1:0] im_wdata_q;
    logic              core_hold_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        err_q;
    logic [ADDR_W:0]   words_loaded_q;
    logic [ADDR_W:0]   words_acc_q;
    logic [ADDR_W:0]   len_q;

    logic              start_acc;
    logic              byte_acc;
    logic              last_byte;
    logic              word_done;
    logic [DATA_W-1:0] word;
    logic [7:0]        csum;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign byte_acc  = in_valid && in_ready_q && (state_q == ST_LOAD);

    word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk          (clk),
        .rest         (rest),
        .clear_i      (start_acc),
        .byte_valid_i (byte_acc),
        .byte_i       (in_byte),
        .last_byte_o  (last_byte),
        .word_done_o  (word_done),
        .word_o       (word),
        .csum_o       (csum)
    );

    // words_acc_q counts words whose last byte is in; it drops in_ready for
    // the one cycle between the final data byte and the final write.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q        <= ST_IDLE;
            in_ready_q     <= 1'b0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            core_hold_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= ERR_NONE;
            words_loaded_q <= '0;
            words_acc_q    <= '0;
            len_q          <= '0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_acc) begin
                        words_loaded_q <= '0;
                        words_acc_q    <= '0;
                        len_q          <= len;
                        done_q         <= 1'b0;
                        core_hold_q    <= 1'b1;
                        if (len == '0 || len > DEPTH) begin
                            state_q    <= ST_ERR;
                            err_q      <= ERR_LEN;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q    <= ST_LOAD;
                            err_q      <= ERR_NONE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (byte_acc && last_byte) begin
                        words_acc_q <= words_acc_q + ONE;
                        if (words_acc_q + ONE == len_q) begin
                            in_ready_q <= 1'b0;
                        end
                    end
                    if (word_done) begin
                        im_we_q        <= 1'b1;
                        im_addr_q      <= words_loaded_q[ADDR_W-1:0];
                        im_wdata_q     <= word;
                        words_loaded_q <= words_loaded_q + ONE;
                        if (words_loaded_q + ONE == len_q) begin
                            state_q    <= ST_CHECK;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_byte == csum) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign core_hold    = core_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and checked by a monitor.
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rest = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = '0;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int last_addr = -1;
    wr_t exp_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rest         (rest),
        .start        (start),
        .len          (len),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int addr, input logic [DATA_W-1:0] data);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int budget = 200;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
    endtask

    function automatic logic [DATA_W-1:0] tw(input int w);
        logic [7:0] v;
        v = 8'(w);
        return {v, 8'hC3 ^ v, 8'h10 + v, ~v};
    endfunction

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rest && im_we) begin
                checks++;
                n_writes++;
                last_addr = int'(im_addr);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h required=no_write", im_addr, im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (im_addr !== e.addr || im_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                                 im_addr, im_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cs;
        logic [DATA_W-1:0] wd;
        logic [7:0] stream [8];
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_core_hold", core_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        rest = 1'b1;
        @(negedge clk);

        // Clean load; XOR of the eight data bytes is 0x44.
        push_wr(0, 32'h11223344);
        push_wr(1, 32'hAABBCCDD);
        do_start(2);
        chk("start_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        for (int i = 0; i < 8; i++) send_byte(stream[i]);
        chk("last_byte_gap_ready", in_ready, 0);
        send_byte(8'h44);
        wait_idle();
        chk("clean_done", done, 1);
        chk("clean_hold", core_hold, 0);
        chk("clean_err", err, 0);
        chk("clean_words", words_loaded, 2);
        chk("clean_nwrites", n_writes, 2);

        // Bad checksum: words still land, then ERR.
        push_wr(0, 32'h11223344);
        push_wr(1, 32'hAABBCCDD);
        do_start(2);
        chk("bad_cs_done_cleared", done, 0);
        for (int i = 0; i < 8; i++) send_byte(stream[i]);
        send_byte(8'h5A);
        wait_idle();
        chk("bad_cs_err", err, 2);
        chk("bad_cs_hold", core_hold, 1);
        chk("bad_cs_done", done, 0);
        chk("bad_cs_words", words_loaded, 2);

        // Bad lengths.
        do_start(0);
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("len0_ready", in_ready, 0);
        do_start(33);
        chk("len33_err", err, 1);
        chk("len33_ready", in_ready, 0);
        chk("len33_hold", core_hold, 1);

        // Full-depth throttled load with start pulses injected in the gaps.
        n_writes = 0;
        cs = 8'h00;
        do_start(32);
        for (int w = 0; w < 32; w++) begin
            wd = tw(w);
            push_wr(w, wd);
            for (int b = 3; b >= 0; b--) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    start = ($urandom_range(0, 2) == 0);
                    len = 6'd5;
                    @(negedge clk);
                    start = 1'b0;
                end
                cs = cs ^ wd[b*8 +: 8];
                send_byte(wd[b*8 +: 8]);
            end
        end
        repeat (2) @(negedge clk);
        do_start(1);
        chk("check_start_ignored_busy", busy, 1);
        chk("check_start_ignored_words", words_loaded, 32);
        send_byte(cs);
        wait_idle();
        chk("full_done", done, 1);
        chk("full_words", words_loaded, 32);
        chk("full_nwrites", n_writes, 32);
        chk("full_last_addr", last_addr, 31);

        // Reset after five bytes of a two-word load.
        push_wr(0, 32'h01020304);
        do_start(2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        #2 rest = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_im_we", im_we, 0);
        chk("mid_rst_im_wdata", im_wdata, 0);
        chk("mid_rst_im_addr", im_addr, 0);
        chk("mid_rst_hold", core_hold, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_words", words_loaded, 0);
        @(negedge clk);
        rest = 1'b1;
        @(negedge clk);

        push_wr(0, 32'hDEADBEEF);
        do_start(1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h22);
        wait_idle();
        chk("post_rst_done", done, 1);
        chk("post_rst_hold", core_hold, 0);
        chk("post_rst_words", words_loaded, 1);

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
